conv_window_fetch: RTL
======================

// Module: conv_window_fetch
// PURPOSE
//  Sequences both ports of the dual-port image SRAM to gather a 3x3 pixel window per output position,
//  raster order over an IMG_W x IMG_H frame. Hands each window to the convolution MAC via valid/ready.
//  Read-only master: both write enables are held inactive (high).
// PARAMETERS
//  IMG_W      256  frame width in pixels
//  IMG_H      256  frame height in pixels
//  ADDR_W     16   SRAM address width
//  DATA_W     8    pixel width
//  BASE_ADDR  0    SRAM address of pixel (0,0); pixel (r,c) at BASE_ADDR + r*IMG_W + c
// PORTS
//  clk         in   1          single clock; async active-low reset rst_n
//  rst_n       in   1          asynchronous, active-low reset
//  start       in   1          pulse: begin frame (ignored while busy)
//  busy        out  1          high from start accept until done
//  done        out  1          1-cycle pulse after last window handshake
//  sram_ena    out  1          port A enable
//  sram_enb    out  1          port B enable
//  sram_wena   out  1          port A write enable, active-low; constant 1
//  sram_wenb   out  1          port B write enable, active-low; constant 1
//  sram_addra  out  ADDR_W     port A address
//  sram_addrb  out  ADDR_W     port B address
//  sram_qa     in   DATA_W     port A read data, valid 1 cycle after enable
//  sram_qb     in   DATA_W     port B read data, valid 1 cycle after enable
//  win_valid   out  1          window available
//  win_ready   in   1          MAC accepts window
//  win_data    out  9*DATA_W   tap k at [DATA_W*k +: DATA_W], k=(dr+1)*3+(dc+1), dr,dc in {-1,0,1}
//  win_row     out  16         output row of current window
//  win_col     out  16         output column of current window
// BEHAVIOUR
//  Reset: all outputs 0 except sram_wena=sram_wenb=1; state IDLE, row=col=0, window regs 0.
//  FSM: IDLE -start-> FETCH(c=0..4) -> LAST -> OUT -(win_valid&win_ready)-> FETCH next pos | DONE -> IDLE.
//  FETCH cycle c: port A reads tap 2c (c=0..4); port B reads tap 2c+1 (c=0..3), idle at c=4.
//  Capture: data of cycle-c reads latched at the edge ending cycle c+1; last tap captured in LAST.
//  OUT: win_valid=1; win_data/win_row/win_col stable while win_valid & !win_ready; no SRAM enables.
//  Latency: FETCH entry to win_valid = 6 cycles; throughput = 7 cycles/window with win_ready held 1.
//  Position advance on handshake: col+1; at col=IMG_W-1 wrap col=0, row+1; at last pixel -> DONE.
//  DONE: done=1 one cycle, busy deasserts same cycle; IDLE next.
//  Border: tap with r+dr or c+dc outside frame -> port enable low that cycle, tap value forced 0.
//  Address arithmetic in ADDR_W bits, computed only for in-bounds taps (no negative wrap).
//  start while busy: ignored. start same cycle as DONE: ignored.
//  rst_n low mid-frame: immediate return to reset values; next start restarts at (0,0).
// CONFIGURATION
//  BORDER_REPLICATE_EN defined: out-of-bounds coordinates clamped to [0,IMG_W-1]/[0,IMG_H-1];
//    read always issued, tap = nearest edge pixel.
//  Undefined (default): zero padding as above, no read issued for out-of-bounds taps.
// TESTING (IMG_W=IMG_H=4, BASE_ADDR=0, SRAM preloaded ram[a]=a+1)
//  Reset -> busy=done=win_valid=0, ena=enb=0, wena=wenb=1, win_data=0.
//  start, window (1,1) -> taps k0..8 = 1,2,3,5,6,7,9,10,11; win_valid 6 cycles after FETCH entry.
//  Window (0,0) zero-pad -> taps = 0,0,0,0,1,2,0,5,6; no enable on cycles for taps 0-3,6.
//  Hold win_ready=0 10 cycles in OUT -> win_data/row/col unchanged, ena=enb=0 throughout.
//  win_ready=1 whole frame -> 16 handshakes in raster order, done pulses once at cycle 112, busy falls.
//  rst_n low during FETCH of (2,1) -> outputs to reset values; new start -> first window (0,0).
//  BORDER_REPLICATE_EN, window (0,0) -> taps = 1,1,2,1,1,2,5,5,6.

Source files
------------

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: walks an IMG_W x IMG_H frame in raster order and, for
// every output position, reads its 3x3 neighbourhood from a dual-port SRAM
// (two taps per cycle), then offers the assembled window over valid/ready.
// Both SRAM ports are used read-only; write enables stay inactive (high).
// Build option: define BORDER_REPLICATE_EN to clamp out-of-frame taps to the
// nearest edge pixel; by default such taps are zero and no read is issued.
module conv_window_fetch #(
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                sram_ena,
    output logic                sram_enb,
    output logic                sram_wena,
    output logic                sram_wenb,
    output logic [ADDR_W-1:0]   sram_addra,
    output logic [ADDR_W-1:0]   sram_addrb,
    input  logic [DATA_W-1:0]   sram_qa,
    input  logic [DATA_W-1:0]   sram_qb,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [9*DATA_W-1:0] win_data,
    output logic [15:0]         win_row,
    output logic [15:0]         win_col
);

    localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
    localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LAST  = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Row of tap k around centre row r, clamped so it never leaves the frame.
    function automatic logic [15:0] tap_row(input logic [15:0] r, input logic [3:0] k);
        logic [15:0] t;
        case (k)
            4'd0, 4'd1, 4'd2: t = (r == 16'd0) ? r : r - 16'd1;
            4'd6, 4'd7, 4'd8: t = (r == LAST_ROW) ? r : r + 16'd1;
            default:          t = r;
        endcase
        return t;
    endfunction

    // Column of tap k around centre column c, clamped to the frame.
    function automatic logic [15:0] tap_col(input logic [15:0] c, input logic [3:0] k);
        logic [15:0] t;
        case (k)
            4'd0, 4'd3, 4'd6: t = (c == 16'd0) ? c : c - 16'd1;
            4'd2, 4'd5, 4'd8: t = (c == LAST_COL) ? c : c + 16'd1;
            default:          t = c;
        endcase
        return t;
    endfunction

    // True when tap k of centre (r,c) lies inside the frame.
    function automatic logic tap_inb(input logic [15:0] r, input logic [15:0] c,
                                     input logic [3:0] k);
        logic row_ok;
        logic col_ok;
        case (k)
            4'd0, 4'd1, 4'd2: row_ok = (r != 16'd0);
            4'd6, 4'd7, 4'd8: row_ok = (r != LAST_ROW);
            default:          row_ok = 1'b1;
        endcase
        case (k)
            4'd0, 4'd3, 4'd6: col_ok = (c != 16'd0);
            4'd2, 4'd5, 4'd8: col_ok = (c != LAST_COL);
            default:          col_ok = 1'b1;
        endcase
        return row_ok & col_ok;
    endfunction

    // Whether a read is issued for tap k (always, when replicating edges).
    function automatic logic tap_en(input logic [15:0] r, input logic [15:0] c,
                                    input logic [3:0] k);
`ifdef BORDER_REPLICATE_EN
        return 1'b1 | tap_inb(r, c, k);
`else
        return tap_inb(r, c, k);
`endif
    endfunction

    // Linear SRAM address of tap k; coordinates are clamped so no negative wrap occurs.
    function automatic logic [ADDR_W-1:0] tap_addr(input logic [15:0] r, input logic [15:0] c,
                                                   input logic [3:0] k);
        logic [31:0] lin;
        lin = 32'(tap_row(r, k)) * 32'(IMG_W) + 32'(tap_col(c, k)) + 32'(BASE_ADDR);
        return lin[ADDR_W-1:0];
    endfunction

    state_t               state_r, state_nx;
    logic [2:0]           cnt_r, cnt_nx;
    logic [15:0]          row_r, row_nx;
    logic [15:0]          col_r, col_nx;

    logic                 busy_r, done_r, win_valid_r;
    logic                 sram_ena_r, sram_enb_r;
    logic [ADDR_W-1:0]    sram_addra_r, sram_addrb_r;
    logic [9*DATA_W-1:0]  win_data_r, win_nx_s;

    logic                 cap_vld_r, cap_a_r, cap_b_r;
    logic [2:0]           cap_cnt_r;
    logic [3:0]           cap_ka_s, cap_kb_s;
    logic [DATA_W-1:0]    a_val_s, b_val_s;

    logic [3:0]           ka_s, kb_s;
    logic                 ena_nx_s, enb_nx_s;
    logic [ADDR_W-1:0]    addra_nx_s, addrb_nx_s;

    // Next-state, fetch-cycle counter and raster position.
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        row_nx   = row_r;
        col_nx   = col_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_FETCH;
                    cnt_nx   = 3'd0;
                    row_nx   = 16'd0;
                    col_nx   = 16'd0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_FETCH: begin
                if (cnt_r == 3'd4) begin
                    state_nx = S_LAST;
                    cnt_nx   = 3'd0;
                end else begin
                    cnt_nx   = cnt_r + 3'd1;
                end
            end
            S_LAST: begin
                state_nx = S_OUT;
            end
            S_OUT: begin
                if (win_ready) begin
                    if ((row_r == LAST_ROW) && (col_r == LAST_COL)) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_FETCH;
                        cnt_nx   = 3'd0;
                        if (col_r == LAST_COL) begin
                            col_nx = 16'd0;
                            row_nx = row_r + 16'd1;
                        end else begin
                            col_nx = col_r + 16'd1;
                        end
                    end
                end else begin
                    state_nx = S_OUT;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Read requests for the next cycle: port A takes tap 2c, port B tap 2c+1.
    always_comb begin
        ka_s       = {cnt_nx, 1'b0};
        kb_s       = ka_s + 4'd1;
        ena_nx_s   = (state_nx == S_FETCH) && tap_en(row_nx, col_nx, ka_s);
        enb_nx_s   = (state_nx == S_FETCH) && (cnt_nx != 3'd4) && tap_en(row_nx, col_nx, kb_s);
        addra_nx_s = ena_nx_s ? tap_addr(row_nx, col_nx, ka_s) : {ADDR_W{1'b0}};
        addrb_nx_s = enb_nx_s ? tap_addr(row_nx, col_nx, kb_s) : {ADDR_W{1'b0}};
    end

    // Window register update: drop returning read data into its tap slot.
    always_comb begin
        cap_ka_s = {cap_cnt_r, 1'b0};
        cap_kb_s = cap_ka_s + 4'd1;
        a_val_s  = cap_a_r ? sram_qa : {DATA_W{1'b0}};
        b_val_s  = cap_b_r ? sram_qb : {DATA_W{1'b0}};
        win_nx_s = win_data_r;
        for (int k = 0; k < 9; k++) begin
            win_nx_s[DATA_W*k +: DATA_W] =
                (cap_vld_r && (4'(k) == cap_ka_s)) ? a_val_s :
                ((cap_vld_r && (cap_cnt_r != 3'd4) && (4'(k) == cap_kb_s)) ? b_val_s :
                 win_data_r[DATA_W*k +: DATA_W]);
        end
    end

    // State, position, registered outputs and read-return bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            cnt_r        <= 3'd0;
            row_r        <= 16'd0;
            col_r        <= 16'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            win_valid_r  <= 1'b0;
            sram_ena_r   <= 1'b0;
            sram_enb_r   <= 1'b0;
            sram_addra_r <= {ADDR_W{1'b0}};
            sram_addrb_r <= {ADDR_W{1'b0}};
            cap_vld_r    <= 1'b0;
            cap_cnt_r    <= 3'd0;
            cap_a_r      <= 1'b0;
            cap_b_r      <= 1'b0;
            win_data_r   <= {(9*DATA_W){1'b0}};
        end else begin
            state_r      <= state_nx;
            cnt_r        <= cnt_nx;
            row_r        <= row_nx;
            col_r        <= col_nx;
            busy_r       <= (state_nx == S_FETCH) || (state_nx == S_LAST) || (state_nx == S_OUT);
            done_r       <= (state_nx == S_DONE);
            win_valid_r  <= (state_nx == S_OUT);
            sram_ena_r   <= ena_nx_s;
            sram_enb_r   <= enb_nx_s;
            sram_addra_r <= addra_nx_s;
            sram_addrb_r <= addrb_nx_s;
            cap_vld_r    <= (state_r == S_FETCH);
            cap_cnt_r    <= cnt_r;
            cap_a_r      <= sram_ena_r;
            cap_b_r      <= sram_enb_r;
            win_data_r   <= win_nx_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign win_valid  = win_valid_r;
    assign sram_ena   = sram_ena_r;
    assign sram_enb   = sram_enb_r;
    assign sram_wena  = 1'b1;
    assign sram_wenb  = 1'b1;
    assign sram_addra = sram_addra_r;
    assign sram_addrb = sram_addrb_r;
    assign win_data   = win_data_r;
    assign win_row    = row_r;
    assign win_col    = col_r;

endmodule
